// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding and handshake helper shared by the pipeline registers.
package pipe_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   function automatic logic fire(input logic valid, input logic ready);
      return valid && ready;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counts cycles with inc high and sticks at the all-ones value.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] count_q, count_d;

   assign count_d = (inc && count_q != {W{1'b1}}) ? count_q + W'(1) : count_q;
   assign count   = count_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) count_q <= '0;
      else       count_q <= count_d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter bit               SKID      = 1'b1,
   parameter int               CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d, skid_val;
   logic             in_fire, out_fire;

   // With SKID the ready path sees only registered state, breaking the out_ready -> in_ready chain.
   assign out_valid = state_q != ST_EMPTY;
   assign in_ready  = !reset && !flush && (SKID ? state_q != ST_TWO : (!out_valid || out_ready));
   assign in_fire   = fire(in_valid, in_ready);
   assign out_fire  = fire(out_valid, out_ready);
   assign out_data  = main_q;
   assign occupancy = state_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = RESET_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_fire) begin
               state_d = ST_ONE;
               main_d  = in_data;
            end
            ST_ONE: begin
               if (in_fire && out_fire) main_d = in_data;
               else if (in_fire)        state_d = ST_TWO;
               else if (out_fire)       state_d = ST_EMPTY;
            end
            ST_TWO: if (out_fire) begin
               state_d = ST_ONE;
               main_d  = skid_val;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end

   generate
      if (SKID) begin : g_skid
         logic [WIDTH-1:0] skid_q;
         always_ff @(posedge clk or posedge reset)
            if (reset)                                        skid_q <= RESET_VAL;
            else if (flush)                                   skid_q <= RESET_VAL;
            else if (state_q == ST_ONE && in_fire && !out_fire) skid_q <= in_data;
         assign skid_val = skid_q;
      end else begin : g_single
         assign skid_val = RESET_VAL;
      end
   endgenerate

   sat_counter #(.W(CNT_W)) u_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random checks of a SKID=0 and a SKID=1 instance against a queue model.
module tb_pipe_skid_reg;
   localparam int         W  = 16;
   localparam logic [W-1:0] RV = 16'h5A5A;

   logic         clk = 1'b0, reset = 1'b1, flush = 1'b0;
   logic [1:0]   iv = '0, ordy = '0, irdy, ov;
   logic [W-1:0] idat [2];
   logic [W-1:0] odat [2];
   logic [1:0]   occ [2];
   logic [7:0]   sc0;
   logic [1:0]   sc1;
   logic [7:0]   scv [2];
   int           compared = 0, mismatched = 0;

   logic [W-1:0] mq [2][$];
   logic [W-1:0] last [2];
   int           st [2];
   bit           fired [2];
   bit           flushed;

   always #5 clk = ~clk;

   assign scv[0] = sc0;
   assign scv[1] = {6'b0, sc1};

   pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b0), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(idat[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]), .flush(flush),
      .occupancy(occ[0]), .stall_cnt(sc0));

   pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(2)) u1 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(idat[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]), .flush(flush),
      .occupancy(occ[1]), .stall_cnt(sc1));

   function automatic logic exp_ir(int k);
      return !reset && !flush && (k == 1 ? mq[k].size() < 2 : (mq[k].size() == 0 || ordy[k]));
   endfunction

   function automatic logic [W-1:0] exp_od(int k);
      return mq[k].size() > 0 ? mq[k][0] : last[k];
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         last[k] = RV;
         st[k] = 0;
         fired[k] = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk("in_ready", k, 32'(irdy[k]), 32'(exp_ir(k)));
         chk("out_valid", k, 32'(ov[k]), 32'(mq[k].size() > 0));
         chk("out_data", k, 32'(odat[k]), 32'(exp_od(k)));
         chk("occupancy", k, 32'(occ[k]), 32'(mq[k].size()));
         chk("stall_cnt", k, 32'(scv[k]), 32'(st[k]));
      end
   endtask

   // Checks settled outputs, then advances the model across one rising edge.
   task automatic clock();
      bit ir, ovl, of;
      #1 check_all();
      @(posedge clk);
      flushed = flush;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            mq[k].delete(); last[k] = RV; st[k] = 0; fired[k] = 1'b0;
         end else begin
            ir  = exp_ir(k);
            ovl = mq[k].size() > 0;
            of  = ovl && ordy[k];
            fired[k] = iv[k] && ir;
            if (ovl && !ordy[k] && st[k] < (k == 0 ? 255 : 3)) st[k]++;
            if (flush) begin
               mq[k].delete(); last[k] = RV;
            end else begin
               if (of) last[k] = mq[k].pop_front();
               if (fired[k]) mq[k].push_back(idat[k]);
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int es [6] = '{1, 2, 3, 3, 3, 3};
      logic r;
      idat[0] = '0; idat[1] = '0;
      model_reset();
      @(negedge clk);
      clock();
      clock();
      reset = 1'b0;
      clock();
      for (int v = 1; v <= 3; v++) begin
         iv = 2'b11; ordy = 2'b11; idat[0] = W'(v); idat[1] = W'(v);
         clock();
         chk("stream_data", 0, 32'(odat[0]), v);
         chk("stream_data", 1, 32'(odat[1]), v);
         chk("stream_occ", 1, 32'(occ[1]), 1);
      end
      iv = '0;
      clock();
      chk("drained", 1, 32'(ov[1]), 0);
      ordy = '0;
      iv[1] = 1'b1; idat[1] = 16'h000A;
      clock();
      chk("occ_one", 1, 32'(occ[1]), 1);
      chk("stall_first", 1, 32'(sc1), 0);
      idat[1] = 16'h000B;
      clock();
      chk("occ_two", 1, 32'(occ[1]), 2);
      chk("ready_full", 1, 32'(irdy[1]), 0);
      chk("stall_seq", 1, 32'(sc1), es[0]);
      iv[1] = 1'b0;
      for (int i = 1; i < 6; i++) begin
         clock();
         chk("stall_seq", 1, 32'(sc1), es[i]);
      end
      ordy[1] = 1'b1;
      chk("first_out", 1, 32'(odat[1]), 16'h000A);
      clock();
      chk("second_out", 1, 32'(odat[1]), 16'h000B);
      clock();
      chk("empty_after", 1, 32'(ov[1]), 0);
      ordy[1] = 1'b0; iv[1] = 1'b1; idat[1] = 16'h00C0;
      clock();
      idat[1] = 16'h00D0;
      clock();
      iv[1] = 1'b0;
      chk("pre_flush_occ", 1, 32'(occ[1]), 2);
      flush = 1'b1;
      #1 chk("flush_ready", 1, 32'(irdy[1]), 0);
      chk("flush_ready", 0, 32'(irdy[0]), 0);
      clock();
      flush = 1'b0;
      chk("flush_valid", 1, 32'(ov[1]), 0);
      chk("flush_occ", 1, 32'(occ[1]), 0);
      chk("flush_data", 1, 32'(odat[1]), RV);
      clock();
      for (int n = 0; n < 1000; n++) begin
         for (int k = 0; k < 2; k++)
            if (!iv[k] || fired[k] || flushed) begin
               iv[k] = $urandom_range(0, 3) != 0;
               idat[k] = W'($urandom);
            end
         ordy = 2'($urandom);
         flush = $urandom_range(0, 31) == 0;
         #1 r = irdy[1];
         ordy[1] = ~ordy[1];
         #1 chk("ready_indep", 1, 32'(irdy[1]), 32'(r));
         ordy[1] = ~ordy[1];
         clock();
      end
      flush = 1'b0; iv = '0; ordy = '0;
      clock();
      iv[1] = 1'b1; idat[1] = 16'h00E0;
      clock();
      idat[1] = 16'h00F0;
      clock();
      iv[1] = 1'b0;
      chk("pre_reset_occ", 1, 32'(occ[1]), 2);
      #2 reset = 1'b1;
      #1 chk("async_valid", 1, 32'(ov[1]), 0);
      chk("async_occ", 1, 32'(occ[1]), 0);
      chk("async_data", 1, 32'(odat[1]), RV);
      chk("async_stall", 1, 32'(sc1), 0);
      chk("async_ready", 1, 32'(irdy[1]), 0);
      model_reset();
      @(negedge clk);
      clock();
      reset = 1'b0;
      clock();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
